// File: rtl/gate_chk_pkg.sv
// Shared types and golden truth table for the two-input gate result checker.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package gate_chk_pkg;

    // Checker run state: waiting for start, watching the inputs, reporting completion.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit positions of each gate output inside the 7-bit gate vector.
    localparam int GATE_W = 7;
    localparam int IDX_D  = 6;   // AND
    localparam int IDX_O  = 5;   // OR
    localparam int IDX_NT = 4;   // NOT A
    localparam int IDX_ND = 3;   // NAND
    localparam int IDX_NR = 2;   // NOR
    localparam int IDX_XR = 1;   // XOR
    localparam int IDX_XN = 0;   // XNOR

    // Number of distinct {A,B} input combinations that must be covered.
    localparam int NUM_COMB = 4;

    // Expected gate vector for a given input pair.
    function automatic logic [GATE_W-1:0] gate_golden(input logic a, input logic b);
        logic [GATE_W-1:0] v;
        v         = '0;
        v[IDX_D]  = a & b;
        v[IDX_O]  = a | b;
        v[IDX_NT] = ~a;
        v[IDX_ND] = ~(a & b);
        v[IDX_NR] = ~(a | b);
        v[IDX_XR] = a ^ b;
        v[IDX_XN] = ~(a ^ b);
        return v;
    endfunction

endpackage

// File: rtl/gate_expected.sv
// Golden reference: maps the {A,B} pair to the 7-bit vector a correct gate block drives.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module gate_expected
    import gate_chk_pkg::*;
(
    input  logic              i_a,
    input  logic              i_b,
    output logic [GATE_W-1:0] o_exp
);

    // Evaluate the truth table for the current input pair.
    always_comb begin
        o_exp = gate_golden(i_a, i_b);
    end

endmodule

// File: rtl/gate_result_checker.sv
// Samples the gate block once per stable {A,B} interval and checks it against the golden table.
// Latency: sample SETTLE_CYCLES edges after the inputs settle; sample_valid/done one cycle later.
// Backpressure: none; start is ignored while a run is active or completing.
module gate_result_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              A,
    input  logic              B,
    input  logic [GATE_W-1:0] gates,
    output logic              busy,
    output logic              sample_valid,
    output logic [1:0]        sample_ab,
    output logic [CNT_W-1:0]  err_count,
    output logic [GATE_W-1:0] fail_vec,
    output logic [3:0]        cov_mask,
    output logic              done,
    output logic              pass
);

    // The stability counter only needs to reach SETTLE_CYCLES-1.
    localparam int               STAB_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       COV_FULL  = 4'b1111;

    // FSM state
    state_t             r_state;
    state_t             w_state_nxt;

    // Input stability tracking
    logic [1:0]         r_ab_q;
    logic [STAB_W-1:0]  r_stab_cnt;
    logic               r_sampled;

    // Result registers
    logic               r_sample_valid;
    logic [1:0]         r_sample_ab;
    logic [CNT_W-1:0]   r_err_count;
    logic [GATE_W-1:0]  r_fail_vec;
    logic [3:0]         r_cov_mask;
    logic               r_pass;

    // Control strobes from the FSM
    logic               w_start_run;
    logic               w_ab_chg;
    logic               w_do_sample;
    logic               w_complete;

    // Datapath values for the sample in progress
    logic [1:0]         w_ab;
    logic [GATE_W-1:0]  w_exp;
    logic [GATE_W-1:0]  w_mism;
    logic [3:0]         w_cov_nxt;
    logic [CNT_W-1:0]   w_err_nxt;

    assign w_ab = {A, B};

    gate_expected u_gate_expected (
        .i_a   (A),
        .i_b   (B),
        .o_exp (w_exp)
    );

    // Mismatch vector, coverage and saturating error count as they would be after this sample.
    always_comb begin
        w_mism    = gates ^ w_exp;
        w_cov_nxt = r_cov_mask | (4'b0001 << w_ab);
        w_err_nxt = r_err_count;
        if ((|w_mism) && (r_err_count != {CNT_W{1'b1}})) begin
            w_err_nxt = r_err_count + CNT_W'(1);
        end
    end

    // Next-state logic and control strobes; a changed input always beats a pending sample.
    always_comb begin
        w_state_nxt = r_state;
        w_start_run = 1'b0;
        w_ab_chg    = 1'b0;
        w_do_sample = 1'b0;
        w_complete  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_run = 1'b1;
                    w_state_nxt = ARMED;
                end
            end
            ARMED: begin
                busy = 1'b1;
                if (w_ab != r_ab_q) begin
                    w_ab_chg = 1'b1;
                end else if (!r_sampled && (r_stab_cnt == STAB_LAST)) begin
                    w_do_sample = 1'b1;
                    if (w_cov_nxt == COV_FULL) begin
                        w_complete  = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stability window: restart on any input change, count until the one sample per interval.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ab_q     <= 2'b00;
            r_stab_cnt <= '0;
            r_sampled  <= 1'b0;
        end else if (w_start_run || w_ab_chg) begin
            r_ab_q     <= w_ab;
            r_stab_cnt <= '0;
            r_sampled  <= 1'b0;
        end else if (w_do_sample) begin
            r_sampled  <= 1'b1;
        end else if ((r_state == ARMED) && !r_sampled) begin
            r_stab_cnt <= r_stab_cnt + STAB_W'(1);
        end
    end

    // Result accumulation: cleared by start, updated on each sample, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sample_valid <= 1'b0;
            r_sample_ab    <= 2'b00;
            r_err_count    <= '0;
            r_fail_vec     <= '0;
            r_cov_mask     <= '0;
            r_pass         <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            if (w_start_run) begin
                r_err_count <= '0;
                r_fail_vec  <= '0;
                r_cov_mask  <= '0;
                r_pass      <= 1'b0;
            end else if (w_do_sample) begin
                r_sample_valid <= 1'b1;
                r_sample_ab    <= w_ab;
                r_cov_mask     <= w_cov_nxt;
                r_fail_vec     <= r_fail_vec | w_mism;
                r_err_count    <= w_err_nxt;
                if (w_complete) begin
                    r_pass <= (w_err_nxt == '0);
                end
            end
        end
    end

    assign sample_valid = r_sample_valid;
    assign sample_ab    = r_sample_ab;
    assign err_count    = r_err_count;
    assign fail_vec     = r_fail_vec;
    assign cov_mask     = r_cov_mask;
    assign pass         = r_pass;

endmodule

// File: doc/gate_result_checker.md
Name: gate_result_checker

Overview:
- Downstream consumer of the two-input logic-gate block (outputs D=AND, O=OR, NT=NOT A, ND=NAND, NR=NOR, XR=XOR, XN=XNOR).
- Watches the {A,B} pair driving the gate block. After the inputs have been stable for a settle window, it samples the 7 gate outputs once and compares them against a golden truth table.
- Accumulates an error count, a sticky per-gate failure vector and 4-combination coverage. Reports pass/fail once all four input combinations have been checked.

Parameters:
- SETTLE_CYCLES, 4, consecutive stable clock edges required before a sample (min 1).
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a check run.
- A  input  1  gate-block input A, as driven to the gate block.
- B  input  1  gate-block input B, as driven to the gate block.
- gates  input  7  gate-block outputs {D,O,NT,ND,NR,XR,XN}, bit 6 = D … bit 0 = XN.
- busy  output  1  high in ARMED.
- sample_valid  output  1  one-cycle pulse when a sample has been compared.
- sample_ab  output  2  {A,B} of the last sample.
- err_count  output  CNT_W  mismatching samples, saturating.
- fail_vec  output  7  sticky OR of per-bit mismatches, same bit order as gates.
- cov_mask  output  4  bit {A,B} set once that combination has been sampled.
- done  output  1  one-cycle pulse at run completion.
- pass  output  1  valid from done onward: err_count==0.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-low (rst_n).
- Reset (rst_n=0 at a clk edge): state=IDLE; all outputs 0; internal ab_q=0, stab_cnt=0, sampled=0. Reset asserted mid-run aborts the run with no done pulse.
- States:
  - IDLE: on start, load ab_q<={A,B}, stab_cnt<=0, sampled<=0, and clear err_count, fail_vec, cov_mask and pass. Go to ARMED.
  - ARMED: see the per-edge rules below.
  - DONE: lasts exactly one cycle with done=1, then returns to IDLE.
- In IDLE, results (err_count, fail_vec, cov_mask, pass, sample_ab) hold until the next start.
- start is ignored while in ARMED or DONE.
- ARMED, evaluated at each edge:
  - If {A,B}!=ab_q: ab_q<={A,B}, stab_cnt<=0, sampled<=0. A change always restarts the window.
  - Else if sampled==0 and stab_cnt==SETTLE_CYCLES-1: perform the sample and set sampled<=1.
  - Else if sampled==0: stab_cnt++.
  - A sample therefore happens at the SETTLE_CYCLES-th edge after the capture edge. There is exactly one sample per stable interval.
- Sample:
  - exp = golden({A,B}); mism = gates ^ exp.
  - sample_valid=1 next cycle; sample_ab<={A,B}.
  - cov_mask[{A,B}]<=1; fail_vec<=fail_vec|mism.
  - If mism!=0, err_count increments, saturating at 2^CNT_W-1.
  - Returning to an already-covered combination is sampled and checked again.
- Completion: at the sampling edge where cov_mask becomes 4'b1111, go to DONE. pass<=(updated err_count==0). done and the final sample_valid are high in the same cycle.
- Simultaneous events:
  - An input change on the edge that would have sampled wins: no sample.
  - rst_n=0 overrides start and everything else.

Decomposition:
- Shared package gate_chk_pkg:
  - state enum {IDLE, ARMED, DONE};
  - bit-index constants IDX_D=6 … IDX_XN=0;
  - golden function returning the 7-bit expected vector from (a,b).
- One sub-module: gate_expected. It is combinational, {A,B} -> 7-bit expected vector, and is reused by the bench scoreboard.

Test Plan:
- Correct gate model, SETTLE_CYCLES=4, AB=00,10,01,11 held 10 cycles each after start:
  - 4 sample_valid pulses, each 4 edges after the change;
  - done once, pass=1, err_count=0, fail_vec=0, cov_mask=1111.
- XR forced 0, same sequence: err_count=2 (AB=01,10), fail_vec=7'b0000010, pass=0.
- AB toggled every 2 cycles for 40 cycles with SETTLE_CYCLES=4: no sample_valid, cov_mask=0, busy stays 1. Then hold AB=11 for 4 edges: exactly one sample.
- rst_n=0 for one cycle after 2 of 4 combinations: all outputs 0, state IDLE, no done. A new start completes normally.
- CNT_W=2, all gates inverted, AB cycled 00,01,10,11,00,01: err_count saturates at 3. done fires after the 4th sample and is not repeated.
- start pulsed again while busy: ignored; the run's counters and coverage are unaffected.
